// File: rtl/jk_bank_scheduler.sv
// rtl/jk_bank_scheduler.sv - two-requester round-robin scheduler applying J-K commands to a bit bank
module jk_bank_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [1:0]       CMD0,
    input  logic [1:0]       CMD1,
    input  logic [WIDTH-1:0] MASK0,
    input  logic [WIDTH-1:0] MASK1,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             BUSY,
    output logic             DONE,
    output logic [7:0]       OPCNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pick1;
    logic             prio;
    logic [1:0]       cmd_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] q_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        // prio set means requester 1 wins a tie; a lone requester always wins
        pick1     = REQ1 && (!REQ0 || prio);
        case (state)
            IDLE:    if (REQ0 || REQ1) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_nxt = Q;
        case (cmd_q)
            2'b01:   q_nxt = Q & ~mask_q;
            2'b10:   q_nxt = Q | mask_q;
            2'b11:   q_nxt = Q ^ mask_q;
            default: q_nxt = Q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            GNT0   <= 1'b0;
            GNT1   <= 1'b0;
            prio   <= 1'b0;
            cmd_q  <= 2'b00;
            mask_q <= '0;
            Q      <= '0;
            OPCNT  <= 8'd0;
        end else begin
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
            if (state == IDLE && (REQ0 || REQ1)) begin
                GNT0   <= !pick1;
                GNT1   <= pick1;
                prio   <= !pick1;
                cmd_q  <= pick1 ? CMD1 : CMD0;
                mask_q <= pick1 ? MASK1 : MASK0;
            end
            if (state == APPLY) begin
                Q     <= q_nxt;
                OPCNT <= OPCNT + 8'd1;
            end
        end
    end

    assign Qbar = ~Q;
    assign BUSY = (state != IDLE);
    assign DONE = (state == SETTLE);

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// tb/tb_jk_bank_scheduler.sv - directed self-checking bench for jk_bank_scheduler
module tb_jk_bank_scheduler;

    logic       CLK;
    logic       RST;
    logic       REQ0;
    logic       REQ1;
    logic [1:0] CMD0;
    logic [1:0] CMD1;
    logic [3:0] MASK0;
    logic [3:0] MASK1;
    logic       GNT0;
    logic       GNT1;
    logic [3:0] Q;
    logic [3:0] Qbar;
    logic       BUSY;
    logic       DONE;
    logic [7:0] OPCNT;

    int         tests_run;
    int         tests_failed;
    logic [7:0] exp_cnt;

    jk_bank_scheduler #(.WIDTH(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ0  (REQ0),
        .REQ1  (REQ1),
        .CMD0  (CMD0),
        .CMD1  (CMD1),
        .MASK0 (MASK0),
        .MASK1 (MASK1),
        .GNT0  (GNT0),
        .GNT1  (GNT1),
        .Q     (Q),
        .Qbar  (Qbar),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OPCNT (OPCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // drives one command through a full request/grant/apply/settle sequence, ending in IDLE
    task automatic run_cmd(input bit side, input logic [1:0] cmd, input logic [3:0] mask);
        @(negedge CLK);
        if (side) begin
            REQ1 = 1'b1; CMD1 = cmd; MASK1 = mask;
        end else begin
            REQ0 = 1'b1; CMD0 = cmd; MASK0 = mask;
        end
        @(negedge CLK);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset();
        REQ0 = 1'b1;
        CMD0 = 2'b10;
        MASK0 = 4'hF;
        do_reset();
        REQ0 = 1'b0;
        tests_run++;
        if (Q !== 4'h0 || Qbar !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_q: Q=%h Qbar=%h expected Q=0 Qbar=f", Q, Qbar);
        end
        tests_run++;
        if (OPCNT !== 8'd0 || GNT0 !== 1'b0 || GNT1 !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: OPCNT=%0d GNT0=%b GNT1=%b DONE=%b BUSY=%b expected all 0",
                     OPCNT, GNT0, GNT1, DONE, BUSY);
        end
    endtask

    task automatic test_single_set();
        @(negedge CLK);
        REQ0 = 1'b1; CMD0 = 2'b10; MASK0 = 4'b0101;
        @(negedge CLK);
        tests_run++;
        if (GNT0 !== 1'b1 || GNT1 !== 1'b0 || BUSY !== 1'b1 || DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_grant: GNT0=%b GNT1=%b BUSY=%b DONE=%b expected 1 0 1 0", GNT0, GNT1, BUSY, DONE);
        end
        REQ0 = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (Q !== 4'b0101 || Qbar !== 4'b1010 || DONE !== 1'b1 || OPCNT !== 8'd1 || GNT0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_apply: Q=%b Qbar=%b DONE=%b OPCNT=%0d GNT0=%b expected 0101 1010 1 1 0",
                     Q, Qbar, DONE, OPCNT, GNT0);
        end
        @(negedge CLK);
        tests_run++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: DONE=%b BUSY=%b expected 0 0", DONE, BUSY);
        end
        exp_cnt = 8'd1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'b0001; exp_q[1] = 4'b0011; exp_q[2] = 4'b0010; exp_q[3] = 4'b0000;
        do_reset();
        REQ0 = 1'b1; CMD0 = 2'b11; MASK0 = 4'b0001;
        REQ1 = 1'b1; CMD1 = 2'b11; MASK1 = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            tests_run++;
            if (GNT0 !== (i % 2 == 0) || GNT1 !== (i % 2 == 1)) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: GNT0=%b GNT1=%b expected %b %b", i, GNT0, GNT1, i % 2 == 0, i % 2 == 1);
            end
            @(negedge CLK);
            tests_run++;
            if (Q !== exp_q[i] || DONE !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_q%0d: Q=%b DONE=%b expected %b 1", i, Q, DONE, exp_q[i]);
            end
            @(negedge CLK);
            tests_run++;
            if (GNT0 !== 1'b0 || GNT1 !== 1'b0 || BUSY !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_gap%0d: GNT0=%b GNT1=%b BUSY=%b expected 0 0 0", i, GNT0, GNT1, BUSY);
            end
            exp_cnt = exp_cnt + 8'd1;
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (GNT0 !== 1'b0 || GNT1 !== 1'b0 || OPCNT !== exp_cnt) begin
            tests_failed++;
            $display("FAIL rr_end: GNT0=%b GNT1=%b OPCNT=%0d expected 0 0 %0d", GNT0, GNT1, OPCNT, exp_cnt);
        end
    endtask

    task automatic test_reset_and_hold();
        run_cmd(1'b1, 2'b10, 4'b1111);
        tests_run++;
        if (Q !== 4'b1111) begin
            tests_failed++;
            $display("FAIL preset_all: Q=%b expected 1111", Q);
        end
        run_cmd(1'b1, 2'b01, 4'b1100);
        tests_run++;
        if (Q !== 4'b0011 || Qbar !== 4'b1100 || OPCNT !== exp_cnt) begin
            tests_failed++;
            $display("FAIL cmd_reset: Q=%b Qbar=%b OPCNT=%0d expected 0011 1100 %0d", Q, Qbar, OPCNT, exp_cnt);
        end
        run_cmd(1'b1, 2'b00, 4'b1111);
        tests_run++;
        if (Q !== 4'b0011 || OPCNT !== exp_cnt) begin
            tests_failed++;
            $display("FAIL cmd_hold: Q=%b OPCNT=%0d expected 0011 %0d", Q, OPCNT, exp_cnt);
        end
    endtask

    task automatic test_busy_ignore();
        @(negedge CLK);
        REQ0 = 1'b1; CMD0 = 2'b00; MASK0 = 4'b0000;
        @(negedge CLK);
        REQ0 = 1'b0;
        REQ1 = 1'b1; CMD1 = 2'b11; MASK1 = 4'b1111;
        @(negedge CLK);
        REQ1 = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            tests_run++;
            if (GNT1 !== 1'b0 || Q !== 4'b0011) begin
                tests_failed++;
                $display("FAIL busy_ignore%0d: GNT1=%b Q=%b expected 0 0011", i, GNT1, Q);
            end
        end
        tests_run++;
        if (OPCNT !== exp_cnt) begin
            tests_failed++;
            $display("FAIL busy_cnt: OPCNT=%0d expected %0d", OPCNT, exp_cnt);
        end
    endtask

    task automatic test_reset_in_apply();
        @(negedge CLK);
        REQ0 = 1'b1; CMD0 = 2'b10; MASK0 = 4'b1111;
        @(negedge CLK);
        REQ0 = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_cnt = 8'd0;
        tests_run++;
        if (Q !== 4'b0000 || OPCNT !== 8'd0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_apply: Q=%b OPCNT=%0d DONE=%b BUSY=%b expected 0000 0 0 0", Q, OPCNT, DONE, BUSY);
        end
        @(negedge CLK);
        tests_run++;
        if (DONE !== 1'b0 || GNT0 !== 1'b0 || Q !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_apply_after: DONE=%b GNT0=%b Q=%b expected 0 0 0000", DONE, GNT0, Q);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int grants;
        int overlaps;
        do_reset();
        grants = 0;
        overlaps = 0;
        REQ0 = 1'b1; CMD0 = 2'b00; MASK0 = 4'hF;
        REQ1 = 1'b1; CMD1 = 2'b00; MASK1 = 4'hF;
        for (int c = 0; c < 1000 && grants < 256; c++) begin
            @(negedge CLK);
            if (GNT0 && GNT1) overlaps++;
            if (GNT0 || GNT1) grants++;
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (GNT0 && GNT1) overlaps++;
            if (GNT0 || GNT1) grants++;
        end
        tests_run++;
        if (grants !== 256) begin
            tests_failed++;
            $display("FAIL wrap_grants: got %0d expected 256", grants);
        end
        tests_run++;
        if (overlaps !== 0) begin
            tests_failed++;
            $display("FAIL wrap_overlap: got %0d expected 0", overlaps);
        end
        tests_run++;
        if (OPCNT !== 8'd0 || BUSY !== 1'b0 || Q !== 4'b0000) begin
            tests_failed++;
            $display("FAIL wrap_opcnt: OPCNT=%0d BUSY=%b Q=%b expected 0 0 0000", OPCNT, BUSY, Q);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        exp_cnt = 8'd0;
        RST = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0;
        CMD0 = 2'b00; CMD1 = 2'b00;
        MASK0 = 4'h0; MASK1 = 4'h0;
        test_reset();
        test_single_set();
        test_round_robin();
        test_reset_and_hold();
        test_busy_ignore();
        test_reset_in_apply();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
